// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer for the 8080 core: reads opcode plus 0-2 immediate
// bytes at the PC, pulses the PC increment per byte, and hands the instruction on.
module instr_fetch_unit #(
  parameter int PC_SETTLE = 1,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [ADDR_W-1:0]     pc_addr_i,
  output logic                  pc_inc_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  mem_rd_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_W-1:0]     mem_data_i,
  output logic [DATA_W-1:0]     opcode_o,
  output logic [2*DATA_W-1:0]   imm_o,
  output logic [1:0]            len_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ack_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    INC,
    SETTLE,
    DONE
  } state_e;

  localparam logic [1:0] SETTLE_LAST = 2'(PC_SETTLE - 1);

  state_e      state_q;
  state_e      state_d;
  logic [1:0]  byte_idx_q;
  logic [1:0]  settle_cnt_q;
  logic        start_fetch;
  logic        byte_done;
  logic        next_byte;
  logic        more_bytes;
  logic [2:0]  next_count;
  logic [1:0]  decoded_len;

  // 8080 instruction length from the opcode alone
  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    if (((op & 8'hCF) == 8'h01) || (op == 8'h22) || (op == 8'h2A) ||
        (op == 8'h32) || (op == 8'h3A) || ((op & 8'hC7) == 8'hC2) ||
        (op == 8'hC3) || (op == 8'hCB) || ((op & 8'hC7) == 8'hC4) ||
        (op == 8'hCD) || (op == 8'hDD) || (op == 8'hED) || (op == 8'hFD)) begin
      len = 2'd3;
    end else if (((op & 8'hC7) == 8'h06) || ((op & 8'hC7) == 8'hC6) ||
                 (op == 8'hD3) || (op == 8'hDB)) begin
      len = 2'd2;
    end
    return len;
  endfunction

  assign decoded_len = decode_len(mem_data_i[7:0]);
  assign next_count  = {1'b0, byte_idx_q} + 3'd1;
  assign more_bytes  = next_count < {1'b0, len_o};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush overrides every transition; the strobes only fire on real transitions
  always_comb begin
    state_d     = state_q;
    start_fetch = 1'b0;
    byte_done   = 1'b0;
    next_byte   = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d     = FETCH;
            start_fetch = 1'b1;
          end
        end
        FETCH: begin
          if (mem_ready_i) begin
            state_d   = INC;
            byte_done = 1'b1;
          end
        end
        INC: state_d = SETTLE;
        SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            if (more_bytes) begin
              state_d   = FETCH;
              next_byte = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (instr_ack_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_addr_o   <= '0;
      opcode_o     <= '0;
      imm_o        <= '0;
      len_o        <= '0;
      byte_idx_q   <= '0;
      settle_cnt_q <= '0;
    end else begin
      if (start_fetch) begin
        mem_addr_o <= pc_addr_i;
        imm_o      <= '0;
        len_o      <= '0;
        byte_idx_q <= '0;
      end
      // The PC has already advanced by the time SETTLE ends
      if (next_byte) begin
        mem_addr_o <= pc_addr_i;
        byte_idx_q <= byte_idx_q + 2'd1;
      end
      if (byte_done) begin
        unique case (byte_idx_q)
          2'd0: begin
            opcode_o <= mem_data_i;
            len_o    <= decoded_len;
          end
          2'd1:    imm_o[DATA_W-1:0]        <= mem_data_i;
          default: imm_o[2*DATA_W-1:DATA_W] <= mem_data_i;
        endcase
      end
      if ((state_q == SETTLE) && (state_d == SETTLE)) begin
        settle_cnt_q <= settle_cnt_q + 2'd1;
      end else begin
        settle_cnt_q <= '0;
      end
    end
  end

  assign mem_rd_o      = (state_q == FETCH);
  assign pc_inc_o      = (state_q == INC);
  assign instr_valid_o = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed instructions with hand-computed
// expectations, a PC model, and a memory model with optional wait states.
module tb_instr_fetch_unit;

  localparam int SETTLE = 1;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] imm;
    logic [1:0]  len;
    int          vcyc;
    int          incs;
    int          rds;
    logic [15:0] base;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        flush_i;
  logic [15:0] pc_addr_i = '0;
  logic        pc_inc_o;
  logic [15:0] mem_addr_o;
  logic        mem_rd_o;
  logic        mem_ready_i;
  logic [7:0]  mem_data_i;
  logic [7:0]  opcode_o;
  logic [15:0] imm_o;
  logic [1:0]  len_o;
  logic        instr_valid_o;
  logic        instr_ack_i;
  logic        busy_o;

  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [7:0]  mem [0:65535];
  logic [15:0] wait_addr;
  int          wait_cycles;
  int          wait_cnt = 0;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fails = 0;
  int          cyc = 0;
  int          inc_cnt = 0;
  int          rd_cnt = 0;
  int          nread = 0;
  bit          tracking = 1'b0;
  bit          valid_seen = 1'b0;

  instr_fetch_unit #(.PC_SETTLE(SETTLE), .ADDR_W(16), .DATA_W(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .flush_i       (flush_i),
    .pc_addr_i     (pc_addr_i),
    .pc_inc_o      (pc_inc_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rd_o      (mem_rd_o),
    .mem_ready_i   (mem_ready_i),
    .mem_data_i    (mem_data_i),
    .opcode_o      (opcode_o),
    .imm_o         (imm_o),
    .len_o         (len_o),
    .instr_valid_o (instr_valid_o),
    .instr_ack_i   (instr_ack_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Program counter model: loads between tests, otherwise follows pc_inc_o
  always @(posedge clk_i) begin
    if (pc_load) pc_addr_i <= pc_load_val;
    else if (pc_inc_o) pc_addr_i <= pc_addr_i + 16'd1;
  end

  // Memory model: ready is held off for wait_cycles on wait_addr only
  assign mem_data_i  = mem[mem_addr_o];
  assign mem_ready_i = mem_rd_o && ((mem_addr_o != wait_addr) || (wait_cnt >= wait_cycles));

  always @(posedge clk_i) begin
    wait_cnt <= (mem_rd_o && !mem_ready_i) ? wait_cnt + 1 : 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fails++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, required);
    end
  endtask

  // Monitor: counts cycles, pulses and reads per fetch and checks each instruction against the scoreboard
  initial begin
    logic [15:0] exp_addr;
    forever begin
      @(negedge clk_i);
      if (tracking) cyc++;
      if (pc_inc_o) inc_cnt++;
      if (mem_rd_o) begin
        rd_cnt++;
        if (sb.size() > 0) begin
          exp_addr = sb[0].base + 16'(nread);
          checkOutput("read_addr", {16'h0, mem_addr_o}, {16'h0, exp_addr});
        end
        if (mem_ready_i) nread++;
      end
      if (instr_valid_o && !valid_seen) begin
        valid_seen = 1'b1;
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 32'(instr_valid_o), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("valid_cycle", cyc, e.vcyc);
          checkOutput("opcode", {24'h0, opcode_o}, {24'h0, e.op});
          checkOutput("imm", {16'h0, imm_o}, {16'h0, e.imm});
          checkOutput("len", {30'h0, len_o}, {30'h0, e.len});
          checkOutput("pc_inc_count", inc_cnt, e.incs);
          checkOutput("read_cycles", rd_cnt, e.rds);
        end
      end
      if (!instr_valid_o) valid_seen = 1'b0;
      if (start_i && !busy_o && !flush_i && rst_ni) begin
        tracking = 1'b1;
        cyc      = 0;
        inc_cnt  = 0;
        rd_cnt   = 0;
        nread    = 0;
      end
    end
  end

  task automatic loadPc(input logic [15:0] base);
    pc_load_val = base;
    pc_load     = 1'b1;
    @(posedge clk_i); #1;
    pc_load     = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] base, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [1:0] len, input logic [15:0] imm,
                               input int waits, input int ack_delay, input bit start_in_done);
    exp_t x;
    mem[base]         = b0;
    mem[base + 16'd1] = b1;
    mem[base + 16'd2] = b2;
    wait_addr   = base;
    wait_cycles = waits;
    loadPc(base);
    x.op   = b0;
    x.imm  = imm;
    x.len  = len;
    x.vcyc = int'(len) * (2 + SETTLE) + 1 + waits;
    x.incs = int'(len);
    x.rds  = int'(len) + waits;
    x.base = base;
    sb.push_back(x);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (instr_valid_o) break;
      @(posedge clk_i); #1;
    end
    checkOutput("valid_reached", 32'(instr_valid_o), 32'd1);
    for (int k = 0; k < ack_delay; k++) begin
      if (start_in_done && k == 1) start_i = 1'b1;
      checkOutput("done_valid_held", 32'(instr_valid_o), 32'd1);
      checkOutput("done_no_read", 32'(mem_rd_o), 32'd0);
      checkOutput("done_opcode", {24'h0, opcode_o}, {24'h0, b0});
      checkOutput("done_imm", {16'h0, imm_o}, {16'h0, imm});
      @(posedge clk_i); #1;
    end
    start_i     = 1'b0;
    instr_ack_i = 1'b1;
    @(posedge clk_i); #1;
    instr_ack_i = 1'b0;
    checkOutput("ack_drops_valid", 32'(instr_valid_o), 32'd0);
    checkOutput("idle_after_ack", 32'(busy_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput("no_restart", 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    flush_i     = 1'b0;
    instr_ack_i = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    wait_addr   = '0;
    wait_cycles = 0;
    #1;
    checkOutput("reset_ctrl", {28'h0, busy_o, mem_rd_o, pc_inc_o, instr_valid_o}, 32'h0);
    checkOutput("reset_addr", {16'h0, mem_addr_o}, 32'h0);
    checkOutput("reset_data", {6'h0, opcode_o, imm_o, len_o}, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    applyStimulus(16'h0000, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0000, 0, 0, 1'b0);
    applyStimulus(16'h0100, 8'h3E, 8'h42, 8'h00, 2'd2, 16'h0042, 0, 0, 1'b0);
    applyStimulus(16'h0200, 8'hC3, 8'h34, 8'h12, 2'd3, 16'h1234, 0, 0, 1'b0);
    applyStimulus(16'h0210, 8'hCD, 8'h00, 8'h30, 2'd3, 16'h3000, 0, 0, 1'b0);
    applyStimulus(16'h0220, 8'hFD, 8'h78, 8'h56, 2'd3, 16'h5678, 0, 0, 1'b0);
    applyStimulus(16'h0600, 8'hC3, 8'hEF, 8'hBE, 2'd3, 16'hBEEF, 3, 0, 1'b0);
    applyStimulus(16'h0700, 8'hD3, 8'h55, 8'h00, 2'd2, 16'h0055, 0, 5, 1'b1);

    // Flush on the lo-byte read of LXI B
    mem[16'h0300] = 8'h01;
    mem[16'h0301] = 8'hCD;
    mem[16'h0302] = 8'hAB;
    wait_cycles   = 0;
    loadPc(16'h0300);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_rd_o && mem_addr_o == 16'h0301) break;
      @(posedge clk_i); #1;
    end
    checkOutput("lo_fetch_reached", {16'h0, mem_addr_o}, 32'h0301);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    checkOutput("flush_idle", {29'h0, busy_o, mem_rd_o, pc_inc_o}, 32'h0);
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("flush_no_valid", 32'(instr_valid_o), 32'd0);
    checkOutput("flush_inc_count", inc_cnt, 1);

    // Asynchronous reset while in SETTLE after the opcode of MVI B
    mem[16'h0800] = 8'h06;
    mem[16'h0801] = 8'h11;
    loadPc(16'h0800);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pc_inc_o) break;
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
    checkOutput("in_settle", {28'h0, busy_o, mem_rd_o, pc_inc_o, instr_valid_o}, 32'h8);
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_ctrl", {28'h0, busy_o, mem_rd_o, pc_inc_o, instr_valid_o}, 32'h0);
    checkOutput("rst_addr", {16'h0, mem_addr_o}, 32'h0);
    checkOutput("rst_data", {6'h0, opcode_o, imm_o, len_o}, 32'h0);
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_inc_count", inc_cnt, 1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("rst_released_idle", 32'(busy_o), 32'd0);

    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch sequencer for the 8080 core, directly downstream of the program counter.
- Consumes the PC address and drives memory reads through a ready handshake.
- Captures the opcode plus 0-2 immediate bytes, and pulses the PC increment once per byte.
- Presents the complete instruction to the decode/control stage with a valid/ack handshake.

Parameters:
PC_SETTLE, 1, idle cycles after each pc_inc_o pulse before pc_addr_i is trusted (range 1-3)
ADDR_W, 16, address width
DATA_W, 8, data bus width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  begin fetching one instruction; sampled only in IDLE
flush_i  in  1  synchronous abort; returns to IDLE
pc_addr_i  in  16  current PC value
pc_inc_o  out  1  one-cycle PC increment pulse
mem_addr_o  out  16  read address, registered
mem_rd_o  out  1  read request
mem_ready_i  in  1  memory data valid this cycle
mem_data_i  in  8  read data
opcode_o  out  8  fetched opcode
imm_o  out  16  immediate: {hi,lo} for 3-byte, {8'h00,lo} for 2-byte, 0 for 1-byte
len_o  out  2  instruction length, 1-3
instr_valid_o  out  1  instruction complete
instr_ack_i  in  1  consumer accepts instruction
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous: state IDLE. All outputs 0; opcode/imm/len registers 0.
- States: IDLE, FETCH, INC, SETTLE, DONE.
  - A byte counter (0-2) and a latched length select OP, LO or HI.
- IDLE:
  - On start_i, capture pc_addr_i into mem_addr_o, clear imm/len, go to FETCH with byte=0.
- FETCH:
  - mem_rd_o=1; mem_addr_o held stable.
  - On mem_ready_i=1, store mem_data_i and go to INC. Otherwise stay; wait states are unbounded.
  - byte 0: store opcode and latch len from decode.
  - byte 1: store lo.
  - byte 2: store hi.
- INC:
  - pc_inc_o=1 for exactly this cycle; mem_rd_o=0. Go to SETTLE.
- SETTLE:
  - Hold for PC_SETTLE cycles.
  - If byte+1 < len: byte++, recapture pc_addr_i into mem_addr_o, go to FETCH.
  - Else go to DONE.
- DONE:
  - instr_valid_o=1; opcode_o/imm_o/len_o stable.
  - On instr_ack_i, go to IDLE next cycle and drop valid.
  - start_i is ignored in DONE. A new fetch needs IDLE, so back-to-back instructions have one IDLE cycle between them.
- Length decode, combinational on opcode:
  - 3 bytes: 00rp0001 (LXI), 22, 2A, 32, 3A, 11ccc010 (Jcc), C3, CB, 11ccc100 (Ccc), CD, DD, ED, FD.
  - 2 bytes: 00ddd110 (MVI), 11xxx110 (immediate ALU), D3, DB.
  - All other opcodes: 1 byte.
- Latency with zero wait states and start_i sampled in cycle 0:
  - instr_valid_o rises in cycle len*(2+PC_SETTLE)+1.
  - For PC_SETTLE=1 this is cycle 4, 7 or 10 for len 1, 2 or 3.
  - Each wait-state cycle adds 1.
- pc_inc_o count per instruction equals len exactly.
- flush_i:
  - Has priority over all transitions. Next cycle: state IDLE, mem_rd_o=0, pc_inc_o=0, instr_valid_o=0.
  - Captured data is discarded; opcode_o/imm_o are don't-care until the next valid.
  - flush_i coinciding with INC still lets that cycle's pc_inc_o pulse through, because the output is registered from the current state.
  - flush_i with start_i in IDLE: flush wins and no fetch starts.
- mem_ready_i outside FETCH is ignored.
- instr_ack_i outside DONE is ignored.
- Reset asserted mid-fetch forces the reset values immediately, with no further pc_inc_o.

Test Plan:
- Reset, PC=0000, memory[0]=00 (NOP), start_i pulse, ready always 1 -> valid in cycle 4; opcode 00, len 1, imm 0000; one pc_inc_o; mem_rd_o high only cycle 1.
- PC=0100, mem 3E,42 (MVI A) -> valid cycle 7; len 2, imm 0042; mem_addr_o 0100 then 0101; two pc_inc_o pulses.
- PC=0200, mem C3,34,12 (JMP 1234) -> valid cycle 10; len 3, imm 1234; three pulses; also repeat with CD and FD -> len 3.
- mem_ready_i held low 3 cycles on the opcode read -> mem_rd_o and mem_addr_o stable throughout; valid delayed by 3 cycles; pulse count unchanged.
- Hold instr_ack_i low 5 cycles after valid, and pulse start_i during DONE -> outputs stable; no new read; IDLE one cycle after ack.
- flush_i during the lo-byte FETCH of LXI (01) -> IDLE next cycle; exactly one pc_inc_o total; no valid.
- rst_ni low during SETTLE -> all outputs 0 immediately.
